fifo_rd_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_rd_oq.sv | 96 +++++++++
 rtl/fifo_rd_packer.sv | 156 +++++++++++++++
 tb/tb_fifo_rd_packer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the FIFO read-side packer.
// Beat width helper, frame counter width, output queue entry.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FRAME_CNT_W    = 16;
  localparam int OQ_ENTRIES     = 2;

  function automatic int out_width(input int w);
    return 2 * w;
  endfunction

  typedef struct packed {
    logic                          last;
    logic [2*FIFO_WIDTH_DEF-1:0]   data;
  } oq_entry_t;

endpackage

// File: rtl/fifo_rd_oq.sv
// fifo_rd_oq: two-entry output queue holding packed beats.
// Head entry is registered and drives the stream directly.
import fifo_pkg::*;

module fifo_rd_oq #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          push_last_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_data_o,
  output logic          head_last_o,
  output logic          valid_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic          l0_q, l0_d, l1_q, l1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop_ok;

  assign pop_ok = pop_i && (cnt_q != 2'd0);

  // next-state of the two slots; slot 0 is always the head
  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    l0_d  = l0_q;
    l1_d  = l1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push_i) begin
          d0_d  = push_data_i;
          l0_d  = push_last_i;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop_ok) begin
          d0_d = push_data_i;
          l0_d = push_last_i;
        end else if (push_i) begin
          d1_d  = push_data_i;
          l1_d  = push_last_i;
          cnt_d = 2'd2;
        end else if (pop_ok) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop_ok) begin
          d0_d = d1_q;
          l0_d = l1_q;
          if (push_i) begin
            d1_d = push_data_i;
            l1_d = push_last_i;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // slot and count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      l0_q  <= l0_d;
      l1_q  <= l1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_data_o = d0_q;
  assign head_last_o = l0_q;
  assign valid_o     = (cnt_q != 2'd0);
  assign count_o     = cnt_q;

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(push_i && (cnt_q == 2'd2) && !pop_i));

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: reads a FIFO under credit, packs word pairs into beats.
// Optional flush input enabled by defining FIFO_RD_PACKER_FLUSH_EN.
import fifo_pkg::*;

module fifo_rd_packer #(
  parameter int FIFO_WIDTH  = FIFO_WIDTH_DEF,
  parameter int FRAME_BEATS = 64,
  parameter int OQ_DEPTH    = OQ_ENTRIES
) (
  input  logic                         clk_b,
  input  logic                         rst_n,
  input  logic [FIFO_WIDTH-1:0]        fifo_dout,
  input  logic                         fifo_empty,
  output logic                         fifo_ren,
  output logic [2*FIFO_WIDTH-1:0]      m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
`ifdef FIFO_RD_PACKER_FLUSH_EN
  input  logic                         flush,
`endif
  output logic                         m_last,
  output logic [FRAME_CNT_W-1:0]       frame_cnt
);

  localparam int OW = out_width(FIFO_WIDTH);
  localparam logic [3:0] CAP = 4'(2 * OQ_DEPTH);
  localparam logic [FRAME_CNT_W-1:0] LAST_IDX =
    FRAME_CNT_W'(FRAME_BEATS - 1);

  logic                   rd_fire;
  logic                   rd_pending_q, rd_pending_d;
  logic [FIFO_WIDTH-1:0]  lo_q, lo_d;
  logic                   lo_valid_q, lo_valid_d;
  logic [FRAME_CNT_W-1:0] beat_q, beat_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [1:0]             oq_cnt;
  logic                   oq_valid;
  logic                   head_last;
  logic [OW-1:0]          head_data;
  logic                   pop;
  logic                   push;
  logic                   push_last;
  logic [OW-1:0]          push_data;
  logic [3:0]             committed;
  logic [3:0]             avail;
  logic                   beat_end;
  logic                   flush_go;
  logic                   hold_ren;

  assign pop = oq_valid && m_ready;

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic flush_req;
  logic flush_pend_q, flush_pend_d;
  logic oq_room;

  // flush waits for any in-flight word and for queue room
  always_comb begin
    flush_req    = flush || flush_pend_q;
    oq_room      = (oq_cnt != 2'd2) || pop;
    flush_go     = flush_req && !rd_pending_q && oq_room;
    flush_pend_d = flush_req && !flush_go;
    hold_ren     = flush_req;
  end

  // remembers a flush that could not act yet
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) flush_pend_q <= 1'b0;
    else        flush_pend_q <= flush_pend_d;
  end
`else
  assign flush_go = 1'b0;
  assign hold_ren = 1'b0;
`endif

  // read only while words in flight plus queued fit the queue
  always_comb begin
    committed = {1'b0, oq_cnt, 1'b0}
              + {3'b000, lo_valid_q}
              + {3'b000, rd_pending_q};
    avail     = committed - {2'b00, pop, 1'b0};
    fifo_ren  = rst_n && !fifo_empty && !hold_ren && (avail < CAP);
    rd_fire   = fifo_ren && !fifo_empty;
  end

  // capture returning words, pair them, tag with frame position
  always_comb begin
    beat_end     = (beat_q == LAST_IDX);
    rd_pending_d = rd_fire;
    lo_d         = lo_q;
    lo_valid_d   = lo_valid_q;
    beat_d       = beat_q;
    push         = 1'b0;
    push_last    = beat_end;
    push_data    = {fifo_dout, lo_q};
    unique case (1'b1)
      rd_pending_q && lo_valid_q: begin
        push       = 1'b1;
        lo_valid_d = 1'b0;
        beat_d     = beat_end ? '0 : beat_q + 1'b1;
      end
      rd_pending_q && !lo_valid_q: begin
        lo_d       = fifo_dout;
        lo_valid_d = 1'b1;
      end
      flush_go: begin
        push       = lo_valid_q;
        push_data  = {{FIFO_WIDTH{1'b0}}, lo_q};
        push_last  = 1'b1;
        lo_valid_d = 1'b0;
        beat_d     = '0;
      end
      default: ;
    endcase
    frame_d = frame_q
            + {{(FRAME_CNT_W-1){1'b0}}, pop && head_last};
  end

  // read tracking, half-word, beat and frame counters
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      lo_q         <= '0;
      lo_valid_q   <= 1'b0;
      beat_q       <= '0;
      frame_q      <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      lo_q         <= lo_d;
      lo_valid_q   <= lo_valid_d;
      beat_q       <= beat_d;
      frame_q      <= frame_d;
    end
  end

  fifo_rd_oq #(
    .DW (OW)
  ) u_oq (
    .clk_i       (clk_b),
    .rst_ni      (rst_n),
    .push_i      (push),
    .push_last_i (push_last),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_data_o (head_data),
    .head_last_o (head_last),
    .valid_o     (oq_valid),
    .count_o     (oq_cnt)
  );

  assign m_data    = head_data;
  assign m_last    = head_last;
  assign m_valid   = oq_valid;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: table vectors, corner sequences, random scoreboard.
// Flush sequence built when FIFO_RD_PACKER_FLUSH_EN is defined.
module tb_fifo_rd_packer;

  localparam int FB = 4;

  logic        clk_b = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_ren;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] frame_cnt;
  logic        flush;

  always #5 clk_b = ~clk_b;

  fifo_rd_packer #(
    .FRAME_BEATS (FB)
  ) dut (
    .clk_b      (clk_b),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
`ifdef FIFO_RD_PACKER_FLUSH_EN
    .flush      (flush),
`endif
    .m_last     (m_last),
    .frame_cnt  (frame_cnt)
  );

  // FIFO model: registered read, cleared with the packer
  logic [15:0] mem [0:4095];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) rp <= wp;
    else if (fifo_ren && !fifo_empty) begin
      fifo_dout <= mem[rp % 4096];
      rp <= rp + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk_b) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int ready_mode;
  bit sb_en;
  bit gap_chk;
  int exp_idx, beat_no, exp_frames, n_pop, last_pop;
  bit held;
  logic [32:0] held_v;
  logic [32:0] got [$];

  typedef struct {
    int nw;
    int mode;
    int beats;
    int frames;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] v);
    mem[wp % 4096] = v;
    wp++;
  endtask

  // drives m_ready and scores every accepted beat
  task automatic monitor();
    logic [31:0] e;
    bit el;
    forever begin
      @(negedge clk_b);
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'b0;
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = cyc[0];
      endcase
      if (!rst_n) begin
        n_pop = 0; exp_idx = wp; beat_no = 0;
        exp_frames = 0; held = 0; got.delete();
      end else begin
        if (held) begin
          check("hold_stable", 64'({m_valid, m_last, m_data}),
                64'({1'b1, held_v}));
        end
        held = 0;
        if (m_valid && m_ready) begin
          n_pop++;
          got.push_back({m_last, m_data});
          if (gap_chk && n_pop > 1)
            check("beat_gap", 64'(cyc - last_pop), 64'd2);
          last_pop = cyc;
          if (sb_en) begin
            e  = {mem[(exp_idx + 1) % 4096], mem[exp_idx % 4096]};
            el = ((beat_no % FB) == FB - 1);
            check("beat_data", 64'(m_data), 64'(e));
            check("beat_last", 64'(m_last), 64'(el));
            if (el) exp_frames++;
            exp_idx += 2;
            beat_no++;
          end
        end else if (m_valid) begin
          held = 1;
          held_v = {m_last, m_data};
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_b);
    check("rst_state",
          64'({fifo_ren, m_valid, m_last, m_data, frame_cnt}), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int lim);
    for (int i = 0; i < lim && n_pop < n; i++) @(negedge clk_b);
    repeat (4) @(negedge clk_b);
    check("pop_count", 64'(n_pop), 64'(n));
  endtask

  initial begin
    int c0, base, np;
    m_ready = 1'b0;
    flush = 1'b0;
    ready_mode = 0;
    sb_en = 1;
    gap_chk = 0;
    fork
      monitor();
    join_none

    tbl[0] = '{8, 0, 4, 1};
    tbl[1] = '{16, 0, 8, 2};
    tbl[2] = '{3, 0, 1, 0};
    tbl[3] = '{20, 2, 10, 2};
    tbl[4] = '{7, 3, 3, 0};
    for (int k = 0; k < 5; k++) begin
      ready_mode = tbl[k].mode;
      do_reset();
      for (int i = 0; i < tbl[k].nw; i++)
        push_word(16'((k << 8) | (i + 1)));
      wait_pops(tbl[k].beats, 300);
      check("tbl_frames", 64'(frame_cnt), 64'(tbl[k].frames));
      check("tbl_idle", 64'(m_valid), 64'd0);
    end

    // first-beat latency, steady-state rate, reference beats
    ready_mode = 0;
    do_reset();
    gap_chk = 1;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    c0 = cyc;
    #1 check("ren_first", 64'(fifo_ren), 64'd1);
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk_b);
    check("first_valid_lat", 64'(cyc - c0), 64'd3);
    wait_pops(4, 40);
    gap_chk = 0;
    check("ref_b0", 64'(got[0]), 64'({1'b0, 32'h0002_0001}));
    check("ref_b1", 64'(got[1]), 64'({1'b0, 32'h0004_0003}));
    check("ref_b2", 64'(got[2]), 64'({1'b0, 32'h0006_0005}));
    check("ref_b3", 64'(got[3]), 64'({1'b1, 32'h0008_0007}));

    // backpressure: reads stop at queue capacity
    ready_mode = 1;
    do_reset();
    base = rp;
    for (int i = 0; i < 20; i++) push_word(16'($urandom));
    repeat (12) @(negedge clk_b);
    check("bp_reads", 64'(rp - base), 64'd4);
    check("bp_ren", 64'(fifo_ren), 64'd0);
    check("bp_valid", 64'(m_valid), 64'd1);
    ready_mode = 0;
    wait_pops(10, 100);
    check("bp_frames", 64'(frame_cnt), 64'd2);

    // FIFO runs dry mid-pair
    do_reset();
    for (int i = 1; i <= 3; i++) push_word(16'(i));
    repeat (12) @(negedge clk_b);
    check("dry_pops", 64'(n_pop), 64'd1);
    check("dry_valid", 64'(m_valid), 64'd0);
    check("dry_b0", 64'(got[0]), 64'({1'b0, 32'h0002_0001}));
    push_word(16'h0004);
    wait_pops(2, 20);
    check("dry_b1", 64'(got[1]), 64'({1'b0, 32'h0004_0003}));

    // asynchronous reset with reads in flight
    ready_mode = 1;
    do_reset();
    for (int i = 0; i < 20; i++) push_word(16'h0A00 + 16'(i));
    repeat (4) @(negedge clk_b);
    @(posedge clk_b);
    #2 rst_n = 1'b0;
    #1 check("async_rst",
             64'({fifo_ren, m_valid, m_last, m_data, frame_cnt}), 64'd0);
    @(negedge clk_b);
    #2 rst_n = 1'b1;
    @(negedge clk_b);
    ready_mode = 0;
    for (int i = 0; i < 4; i++) push_word(16'h0B00 + 16'(i));
    wait_pops(2, 30);
    check("rst_fresh", 64'(got[0]), 64'({1'b0, 32'h0B01_0B00}));

    // random traffic against the scoreboard
    ready_mode = 2;
    do_reset();
    np = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_b);
      if ($urandom_range(0, 2) == 0 && np < 600) begin
        push_word(16'($urandom));
        np++;
      end
    end
    if (np % 2 == 1) begin
      push_word(16'($urandom));
      np++;
    end
    ready_mode = 0;
    wait_pops(np / 2, 1000);
    check("rand_frames", 64'(frame_cnt), 64'((np / 2) / FB));
    check("rand_sb_frames", 64'(frame_cnt), 64'(exp_frames));

`ifdef FIFO_RD_PACKER_FLUSH_EN
    sb_en = 0;
    do_reset();
    for (int i = 1; i <= 3; i++) push_word(16'(i));
    repeat (10) @(negedge clk_b);
    flush = 1'b1;
    @(negedge clk_b);
    flush = 1'b0;
    wait_pops(2, 20);
    check("fl_b0", 64'(got[0]), 64'({1'b0, 32'h0002_0001}));
    check("fl_b1", 64'(got[1]), 64'({1'b1, 32'h0000_0003}));
    check("fl_frames", 64'(frame_cnt), 64'd1);
    for (int i = 1; i <= 8; i++) push_word(16'h0010 + 16'(i));
    wait_pops(6, 50);
    check("fl_b2", 64'(got[2]), 64'({1'b0, 32'h0012_0011}));
    check("fl_b5", 64'(got[5]), 64'({1'b1, 32'h0018_0017}));
    check("fl_frames2", 64'(frame_cnt), 64'd2);
    sb_en = 1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
